// File: rtl/msi_coherence_fsm_if.sv
// Signal bundle between a processor's cache arrays and its MSI coherence controller.
// master = cache/processor side driving requests and snoops, slave = the controller.
interface msi_coherence_fsm_if #(
  parameter int DATA_W = 8,
  parameter int PROC_W = 2
);
  logic              req_active;
  logic [2:0]        cpu_action;
  logic [1:0]        req_state;
  logic [PROC_W-1:0] req_proc;
  logic              req_wb;
  logic [1:0]        req_next_state;
  logic [2:0]        bus_msg_out;
  logic [PROC_W-1:0] req_proc_out;

  logic              snp_active;
  logic              snp_cache_hit;
  logic [1:0]        snp_state;
  logic [PROC_W-1:0] snp_proc;
  logic [2:0]        bus_msg_in;
  logic [DATA_W-1:0] snp_data;
  logic              snp_wb;
  logic              abort_mem_access;
  logic              snp_hit;
  logic [1:0]        snp_next_state;
  logic [PROC_W-1:0] snp_proc_out;
  logic [DATA_W-1:0] snp_data_out;

  modport master (
    output req_active, cpu_action, req_state, req_proc,
    input  req_wb, req_next_state, bus_msg_out, req_proc_out,
    output snp_active, snp_cache_hit, snp_state, snp_proc, bus_msg_in, snp_data,
    input  snp_wb, abort_mem_access, snp_hit, snp_next_state, snp_proc_out, snp_data_out
  );

  modport slave (
    input  req_active, cpu_action, req_state, req_proc,
    output req_wb, req_next_state, bus_msg_out, req_proc_out,
    input  snp_active, snp_cache_hit, snp_state, snp_proc, bus_msg_in, snp_data,
    output snp_wb, abort_mem_access, snp_hit, snp_next_state, snp_proc_out, snp_data_out
  );
endinterface

// File: rtl/msi_coherence_fsm.sv
// MSI requester/snooper controller for one line slot; every output registered, 1-cycle latency.
// Build option FWD_SHARED_EN: S-state snoop hits on RD_MISS also forward data and abort memory.
module msi_coherence_fsm #(
  parameter int DATA_W = 8,
  parameter int PROC_W = 2
) (
  input logic              clock,
  input logic              reset,
  msi_coherence_fsm_if.slave bus
);
  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  localparam logic [2:0] MSG_NONE    = 3'b000;
  localparam logic [2:0] MSG_RD_MISS = 3'b001;
  localparam logic [2:0] MSG_WR_MISS = 3'b010;
  localparam logic [2:0] MSG_INVAL   = 3'b011;

  localparam logic [2:0] CPU_RD_HIT  = 3'b001;
  localparam logic [2:0] CPU_RD_MISS = 3'b010;
  localparam logic [2:0] CPU_WR_HIT  = 3'b011;
  localparam logic [2:0] CPU_WR_MISS = 3'b100;

  logic [1:0] req_cur, req_nxt;
  logic       req_wb_nxt;
  logic [2:0] req_msg_nxt;

  always_comb begin
    req_cur     = (bus.req_state == 2'b11) ? ST_I : bus.req_state;
    req_nxt     = req_cur;
    req_wb_nxt  = 1'b0;
    req_msg_nxt = MSG_NONE;
    case (req_cur)
      ST_I: begin
        case (bus.cpu_action)
          CPU_RD_MISS: begin req_nxt = ST_S; req_msg_nxt = MSG_RD_MISS; end
          CPU_WR_MISS: begin req_nxt = ST_M; req_msg_nxt = MSG_WR_MISS; end
          default: ;
        endcase
      end
      ST_S: begin
        case (bus.cpu_action)
          CPU_RD_HIT:  req_nxt = ST_S;
          CPU_RD_MISS: begin req_nxt = ST_S; req_msg_nxt = MSG_RD_MISS; end
          CPU_WR_HIT:  begin req_nxt = ST_M; req_msg_nxt = MSG_INVAL; end
          CPU_WR_MISS: begin req_nxt = ST_M; req_msg_nxt = MSG_WR_MISS; end
          default: ;
        endcase
      end
      ST_M: begin
        // A miss in M evicts a dirty victim, hence the write-back.
        case (bus.cpu_action)
          CPU_RD_HIT, CPU_WR_HIT: req_nxt = ST_M;
          CPU_RD_MISS: begin req_nxt = ST_S; req_wb_nxt = 1'b1; req_msg_nxt = MSG_RD_MISS; end
          CPU_WR_MISS: begin req_nxt = ST_M; req_wb_nxt = 1'b1; req_msg_nxt = MSG_WR_MISS; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  logic [1:0] snp_cur, snp_nxt;
  logic       snp_hit_c, snp_wb_nxt, snp_abort_nxt, snp_fwd;

  always_comb begin
    snp_cur       = (bus.snp_state == 2'b11) ? ST_I : bus.snp_state;
    snp_hit_c     = bus.snp_cache_hit && (snp_cur != ST_I);
    snp_nxt       = snp_cur;
    snp_wb_nxt    = 1'b0;
    snp_abort_nxt = 1'b0;
    snp_fwd       = 1'b0;
    if (snp_hit_c) begin
      case (bus.bus_msg_in)
        MSG_RD_MISS: begin
          snp_nxt = ST_S;
          if (snp_cur == ST_M) begin
            snp_wb_nxt    = 1'b1;
            snp_abort_nxt = 1'b1;
            snp_fwd       = 1'b1;
          end
`ifdef FWD_SHARED_EN
          else begin
            snp_abort_nxt = 1'b1;
            snp_fwd       = 1'b1;
          end
`endif
        end
        MSG_WR_MISS: begin
          snp_nxt = ST_I;
          if (snp_cur == ST_M) begin
            snp_wb_nxt    = 1'b1;
            snp_abort_nxt = 1'b1;
            snp_fwd       = 1'b1;
          end
        end
        MSG_INVAL: snp_nxt = ST_I;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.req_wb           <= 1'b0;
      bus.req_next_state   <= ST_I;
      bus.bus_msg_out      <= MSG_NONE;
      bus.req_proc_out     <= '0;
      bus.snp_wb           <= 1'b0;
      bus.abort_mem_access <= 1'b0;
      bus.snp_hit          <= 1'b0;
      bus.snp_next_state   <= ST_I;
      bus.snp_proc_out     <= '0;
      bus.snp_data_out     <= '0;
    end else begin
      if (bus.req_active) begin
        bus.req_wb         <= req_wb_nxt;
        bus.req_next_state <= req_nxt;
        bus.bus_msg_out    <= req_msg_nxt;
        bus.req_proc_out   <= bus.req_proc;
      end else begin
        bus.req_wb      <= 1'b0;
        bus.bus_msg_out <= MSG_NONE;
      end
      // Forwarded data is only refreshed when a cache actually supplies it.
      if (bus.snp_active) begin
        bus.snp_wb           <= snp_wb_nxt;
        bus.abort_mem_access <= snp_abort_nxt;
        bus.snp_hit          <= snp_hit_c;
        bus.snp_next_state   <= snp_nxt;
        bus.snp_proc_out     <= bus.snp_proc;
        if (snp_fwd) bus.snp_data_out <= bus.snp_data;
      end else begin
        bus.snp_wb           <= 1'b0;
        bus.abort_mem_access <= 1'b0;
        bus.snp_hit          <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_msi_coherence_fsm.sv
// Scoreboard bench for msi_coherence_fsm: expected output words queued at drive time, popped one cycle later.
module tb_msi_coherence_fsm;
  logic clock;
  logic reset;

  msi_coherence_fsm_if #(.DATA_W(8), .PROC_W(2)) bus_if ();

  msi_coherence_fsm #(.DATA_W(8), .PROC_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef FWD_SHARED_EN
  localparam logic       FWD_AB = 1'b1;
  localparam logic [7:0] D5     = 8'h30;
`else
  localparam logic       FWD_AB = 1'b0;
  localparam logic [7:0] D5     = 8'hA5;
`endif

  typedef struct packed {
    logic       ra;
    logic [2:0] act;
    logic [1:0] rs;
    logic [1:0] rp;
    logic       sa;
    logic       sh;
    logic [1:0] ss;
    logic [1:0] sp;
    logic [2:0] bm;
    logic [7:0] sd;
  } stim_t;

  typedef struct packed {
    logic [1:0] rns;
    logic       rwb;
    logic [2:0] msg;
    logic [1:0] rpo;
    logic [1:0] sns;
    logic       swb;
    logic       ab;
    logic       shit;
    logic [1:0] spo;
    logic [7:0] sdo;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic apply(input stim_t s);
    bus_if.req_active    = s.ra;
    bus_if.cpu_action    = s.act;
    bus_if.req_state     = s.rs;
    bus_if.req_proc      = s.rp;
    bus_if.snp_active    = s.sa;
    bus_if.snp_cache_hit = s.sh;
    bus_if.snp_state     = s.ss;
    bus_if.snp_proc      = s.sp;
    bus_if.bus_msg_in    = s.bm;
    bus_if.snp_data      = s.sd;
  endtask

  function automatic exp_t sample();
    exp_t o;
    o = {bus_if.req_next_state, bus_if.req_wb, bus_if.bus_msg_out, bus_if.req_proc_out,
         bus_if.snp_next_state, bus_if.snp_wb, bus_if.abort_mem_access, bus_if.snp_hit,
         bus_if.snp_proc_out, bus_if.snp_data_out};
    return o;
  endfunction

  task automatic test_reset();
    exp_t got;
    reset = 1'b0;
    apply('{1'b1, 3'b010, 2'b00, 2'd1, 1'b1, 1'b1, 2'b10, 2'd2, 3'b001, 8'hFF});
    repeat (2) @(posedge clock);
    #1;
    got = sample();
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want %h", got, 23'h0);
    end
    n_checks++;
    if (bus_if.bus_msg_out !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_bus_msg got %b want 000", bus_if.bus_msg_out);
    end
    @(negedge clock);
    apply('0);
    reset = 1'b1;
  endtask

  task automatic test_requester();
    stim_t st[10];
    exp_t  ex[10];
    exp_t  got, want;
    st[0] = '{1'b1, 3'b010, 2'b00, 2'd1, 1'b0, 1'b0, 2'b00, 2'd0, 3'b000, 8'h00};
    ex[0] = '{2'b01, 1'b0, 3'b001, 2'd1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    st[1] = '{1'b1, 3'b100, 2'b00, 2'd2, 1'b0, 1'b0, 2'b00, 2'd0, 3'b000, 8'h00};
    ex[1] = '{2'b10, 1'b0, 3'b010, 2'd2, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    st[2] = '{1'b1, 3'b011, 2'b01, 2'd3, 1'b0, 1'b0, 2'b00, 2'd0, 3'b000, 8'h00};
    ex[2] = '{2'b10, 1'b0, 3'b011, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    st[3] = '{1'b1, 3'b010, 2'b10, 2'd0, 1'b0, 1'b0, 2'b00, 2'd0, 3'b000, 8'h00};
    ex[3] = '{2'b01, 1'b1, 3'b001, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    st[4] = '{1'b1, 3'b100, 2'b10, 2'd1, 1'b0, 1'b0, 2'b00, 2'd0, 3'b000, 8'h00};
    ex[4] = '{2'b10, 1'b1, 3'b010, 2'd1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    st[5] = '{1'b1, 3'b001, 2'b01, 2'd2, 1'b0, 1'b0, 2'b00, 2'd0, 3'b000, 8'h00};
    ex[5] = '{2'b01, 1'b0, 3'b000, 2'd2, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    st[6] = '{1'b1, 3'b001, 2'b00, 2'd3, 1'b0, 1'b0, 2'b00, 2'd0, 3'b000, 8'h00};
    ex[6] = '{2'b00, 1'b0, 3'b000, 2'd3, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    st[7] = '{1'b1, 3'b111, 2'b10, 2'd0, 1'b0, 1'b0, 2'b00, 2'd0, 3'b000, 8'h00};
    ex[7] = '{2'b10, 1'b0, 3'b000, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    st[8] = '{1'b1, 3'b011, 2'b10, 2'd1, 1'b0, 1'b0, 2'b00, 2'd0, 3'b000, 8'h00};
    ex[8] = '{2'b10, 1'b0, 3'b000, 2'd1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    st[9] = '{1'b0, 3'b010, 2'b00, 2'd2, 1'b0, 1'b0, 2'b00, 2'd0, 3'b000, 8'h00};
    ex[9] = '{2'b10, 1'b0, 3'b000, 2'd1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clock);
      #1;
      got  = sample();
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL requester_row%0d got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_snooper();
    stim_t st[10];
    exp_t  ex[10];
    exp_t  got, want;
    st[0] = '{1'b0, 3'b000, 2'b00, 2'd0, 1'b1, 1'b1, 2'b10, 2'd2, 3'b001, 8'h5A};
    ex[0] = '{2'b10, 1'b0, 3'b000, 2'd1, 2'b01, 1'b1, 1'b1, 1'b1, 2'd2, 8'h5A};
    st[1] = '{1'b0, 3'b000, 2'b00, 2'd0, 1'b1, 1'b1, 2'b01, 2'd1, 3'b011, 8'h11};
    ex[1] = '{2'b10, 1'b0, 3'b000, 2'd1, 2'b00, 1'b0, 1'b0, 1'b1, 2'd1, 8'h5A};
    st[2] = '{1'b0, 3'b000, 2'b00, 2'd0, 1'b1, 1'b0, 2'b01, 2'd3, 3'b011, 8'h22};
    ex[2] = '{2'b10, 1'b0, 3'b000, 2'd1, 2'b01, 1'b0, 1'b0, 1'b0, 2'd3, 8'h5A};
    st[3] = '{1'b0, 3'b000, 2'b00, 2'd0, 1'b1, 1'b1, 2'b10, 2'd0, 3'b010, 8'hA5};
    ex[3] = '{2'b10, 1'b0, 3'b000, 2'd1, 2'b00, 1'b1, 1'b1, 1'b1, 2'd0, 8'hA5};
    st[4] = '{1'b0, 3'b000, 2'b00, 2'd0, 1'b1, 1'b1, 2'b01, 2'd1, 3'b001, 8'h30};
    ex[4] = '{2'b10, 1'b0, 3'b000, 2'd1, 2'b01, 1'b0, FWD_AB, 1'b1, 2'd1, D5};
    st[5] = '{1'b0, 3'b000, 2'b00, 2'd0, 1'b1, 1'b1, 2'b10, 2'd2, 3'b101, 8'h44};
    ex[5] = '{2'b10, 1'b0, 3'b000, 2'd1, 2'b10, 1'b0, 1'b0, 1'b1, 2'd2, D5};
    st[6] = '{1'b0, 3'b000, 2'b00, 2'd0, 1'b1, 1'b1, 2'b11, 2'd3, 3'b010, 8'h55};
    ex[6] = '{2'b10, 1'b0, 3'b000, 2'd1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd3, D5};
    st[7] = '{1'b0, 3'b000, 2'b00, 2'd0, 1'b1, 1'b1, 2'b10, 2'd0, 3'b011, 8'h66};
    ex[7] = '{2'b10, 1'b0, 3'b000, 2'd1, 2'b00, 1'b0, 1'b0, 1'b1, 2'd0, D5};
    st[8] = '{1'b0, 3'b000, 2'b00, 2'd0, 1'b1, 1'b1, 2'b01, 2'd1, 3'b010, 8'h77};
    ex[8] = '{2'b10, 1'b0, 3'b000, 2'd1, 2'b00, 1'b0, 1'b0, 1'b1, 2'd1, D5};
    st[9] = '{1'b0, 3'b000, 2'b00, 2'd0, 1'b0, 1'b1, 2'b10, 2'd2, 3'b001, 8'h88};
    ex[9] = '{2'b10, 1'b0, 3'b000, 2'd1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd1, D5};
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clock);
      #1;
      got  = sample();
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL snooper_row%0d got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[3];
    exp_t  ex[3];
    exp_t  got, want;
    st[0] = '{1'b1, 3'b010, 2'b00, 2'd3, 1'b1, 1'b1, 2'b10, 2'd2, 3'b001, 8'hC3};
    ex[0] = '{2'b01, 1'b0, 3'b001, 2'd3, 2'b01, 1'b1, 1'b1, 1'b1, 2'd2, 8'hC3};
    st[1] = '{1'b1, 3'b100, 2'b01, 2'd0, 1'b1, 1'b1, 2'b01, 2'd1, 3'b010, 8'h3C};
    ex[1] = '{2'b10, 1'b0, 3'b010, 2'd0, 2'b00, 1'b0, 1'b0, 1'b1, 2'd1, 8'hC3};
    st[2] = '{1'b1, 3'b001, 2'b10, 2'd1, 1'b1, 1'b1, 2'b10, 2'd0, 3'b010, 8'h99};
    ex[2] = '{2'b10, 1'b0, 3'b000, 2'd1, 2'b00, 1'b1, 1'b1, 1'b1, 2'd0, 8'h99};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clock);
      #1;
      got  = sample();
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL back_to_back_row%0d got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t got;
    @(negedge clock);
    apply('{1'b1, 3'b100, 2'b10, 2'd2, 1'b1, 1'b1, 2'b10, 2'd3, 3'b001, 8'hE7});
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    got = sample();
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async got %h want %h", got, 23'h0);
    end
    @(posedge clock);
    #1;
    got = sample();
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_held got %h want %h", got, 23'h0);
    end
    @(negedge clock);
    apply('0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    got = sample();
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_release got %h want %h", got, 23'h0);
    end
  endtask

  initial begin
    apply('0);
    test_reset();
    test_requester();
    test_snooper();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
